// File: rtl/rv32_isa_pkg.sv
// RV32 ISA constants and request/word types shared by the instruction encoder.
package rv32_isa_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_IALU  = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_LUI   = 3'd4
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [19:0]  imm;
  } enc_req_t;

  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } enc_word_t;

endpackage

// File: rtl/rv32_enc_fifo.sv
// Small synchronous FIFO with count-based full/empty. Head data reads as
// zero while empty so downstream sees a clean idle bus.
module rv32_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Streaming RV32 instruction encoder: field bundle in, legal 32-bit word out
// through a small buffer. Illegal bundles become a flagged, counted NOP.
// Build option: define RV32M_ENCODE_EN to accept R-class funct7=0000001 (M ext).
module rv32_instr_encoder
  import rv32_isa_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [19:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  enc_req_t         w_req;
  enc_word_t        w_word;
  enc_word_t        w_head;
  logic [31:0]      w_raw;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] r_illegal_cnt;

  // Pack the input ports into a request bundle.
  always_comb begin
    w_req.cls    = instr_class_e'(in_class);
    w_req.funct3 = in_funct3;
    w_req.funct7 = in_funct7;
    w_req.rd     = in_rd;
    w_req.rs1    = in_rs1;
    w_req.rs2    = in_rs2;
    w_req.imm    = in_imm;
  end

  // Encode the bundle and judge its legality; reserved classes fall to default.
  always_comb begin
    w_raw   = '0;
    w_legal = 1'b0;
    case (w_req.cls)
      CLS_R: begin
        w_raw = {w_req.funct7, w_req.rs2, w_req.rs1, w_req.funct3, w_req.rd, OP_R};
        if (w_req.funct7 == F7_BASE)
          w_legal = 1'b1;
        else if (w_req.funct7 == F7_ALT)
          w_legal = (w_req.funct3 == 3'b000) || (w_req.funct3 == 3'b101);
`ifdef RV32M_ENCODE_EN
        else if (w_req.funct7 == F7_MULDIV)
          w_legal = 1'b1;
`endif
        else
          w_legal = 1'b0;
      end
      CLS_IALU: begin
        w_raw = {w_req.imm[11:0], w_req.rs1, w_req.funct3, w_req.rd, OP_IMM};
        // Shift-immediates reuse imm[11:5] as a funct7 selector.
        if (w_req.funct3 == 3'b001)
          w_legal = (w_req.imm[11:5] == F7_BASE);
        else if (w_req.funct3 == 3'b101)
          w_legal = (w_req.imm[11:5] == F7_BASE) || (w_req.imm[11:5] == F7_ALT);
        else
          w_legal = 1'b1;
      end
      CLS_LOAD: begin
        w_raw = {w_req.imm[11:0], w_req.rs1, w_req.funct3, w_req.rd, OP_LOAD};
        w_legal = (w_req.funct3 != 3'b011) && (w_req.funct3 != 3'b110) &&
                  (w_req.funct3 != 3'b111);
      end
      CLS_STORE: begin
        w_raw = {w_req.imm[11:5], w_req.rs2, w_req.rs1, w_req.funct3,
                 w_req.imm[4:0], OP_STORE};
        w_legal = (w_req.funct3 == 3'b000) || (w_req.funct3 == 3'b001) ||
                  (w_req.funct3 == 3'b010);
      end
      CLS_LUI: begin
        w_raw   = {w_req.imm, w_req.rd, OP_LUI};
        w_legal = 1'b1;
      end
      default: begin
        w_raw   = '0;
        w_legal = 1'b0;
      end
    endcase
    w_word.illegal = !w_legal;
    w_word.instr   = w_legal ? w_raw : NOP_WORD;
  end

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  rv32_enc_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(enc_word_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_instr   = w_head.instr;
  assign out_illegal = w_head.illegal;
  assign illegal_cnt = r_illegal_cnt;

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk) begin
    if (rst)
      r_illegal_cnt <= '0;
    else if (w_push && w_word.illegal && (r_illegal_cnt != '1))
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: expected words are queued on accept
// and compared when the DUT hands them over.
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [19:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  rv32_instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", {31'd0, out_illegal, out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("word", {31'd0, out_illegal, out_instr}, {31'd0, e});
      end
    end
  end

  task automatic set_req(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [19:0] imm);
    in_class  = c;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Drive one request (called just after a rising edge); returns just after the accept edge.
  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [19:0] imm, input logic ill, input logic [31:0] word);
    bit done = 0;
    set_req(c, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({ill, word});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 20'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    chk("rst_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    out_ready = 1'b1;
    // R ADD, with one-cycle latency check
    send(3'd0, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 20'd0, 1'b0, 32'h002081B3);
    chk("add_latency_valid", {63'd0, out_valid}, 64'd1);
    chk("add_latency_word", {32'd0, out_instr}, 64'h002081B3);
    @(posedge clk); #1;

    // SUB then ADDI back-to-back
    send(3'd0, 3'b000, 7'h20, 5'd5, 5'd6, 5'd7, 20'd0, 1'b0, 32'h407302B3);
    send(3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 20'd5, 1'b0, 32'h00500093);
    // STORE SW
    send(3'd3, 3'b010, 7'h00, 5'd0, 5'd2, 5'd5, 20'd8, 1'b0, 32'h00512423);
    // Illegal SLLI, then reserved class
    send(3'd1, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 20'h00400, 1'b1, 32'h00000013);
    chk("cnt_after_slli", {48'd0, illegal_cnt}, 64'd1);
    send(3'd6, 3'b000, 7'h00, 5'd1, 5'd1, 5'd1, 20'd0, 1'b1, 32'h00000013);
    chk("cnt_after_cls6", {48'd0, illegal_cnt}, 64'd2);

    // More legal/illegal boundary patterns
    send(3'd4, 3'b000, 7'h00, 5'd10, 5'd0, 5'd0, 20'h12345, 1'b0, 32'h12345537);
    send(3'd2, 3'b010, 7'h00, 5'd4, 5'd3, 5'd0, 20'h00FFC, 1'b0, 32'hFFC1A203);
    send(3'd1, 3'b101, 7'h00, 5'd2, 5'd2, 5'd0, 20'h00403, 1'b0, 32'h40315113);
    send(3'd2, 3'b011, 7'h00, 5'd4, 5'd3, 5'd0, 20'd0, 1'b1, 32'h00000013);
    send(3'd3, 3'b011, 7'h00, 5'd0, 5'd2, 5'd5, 20'd0, 1'b1, 32'h00000013);
    send(3'd0, 3'b001, 7'h20, 5'd1, 5'd1, 5'd1, 20'd0, 1'b1, 32'h00000013);
    chk("cnt_after_boundary", {48'd0, illegal_cnt}, 64'd5);

    // MUL depends on the M-extension build option
`ifdef RV32M_ENCODE_EN
    send(3'd0, 3'b000, 7'h01, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0, 32'h023100B3);
    chk("cnt_after_mul", {48'd0, illegal_cnt}, 64'd5);
`else
    send(3'd0, 3'b000, 7'h01, 5'd1, 5'd2, 5'd3, 20'd0, 1'b1, 32'h00000013);
    chk("cnt_after_mul", {48'd0, illegal_cnt}, 64'd6);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("drained_before_bp", {63'd0, out_valid}, 64'd0);

    // Backpressure: fill the buffer, third request must stall
    out_ready = 1'b0;
    send(3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 20'd1, 1'b0, 32'h00100093);
    send(3'd1, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 20'd2, 1'b0, 32'h00200113);
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    set_req(3'd1, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 20'd3);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_head_stable", {31'd0, out_illegal, out_instr}, 64'h00100093);
      chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
    send(3'd1, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 20'd3, 1'b0, 32'h00300193);
    send(3'd1, 3'b000, 7'h00, 5'd4, 5'd0, 5'd0, 20'd4, 1'b0, 32'h00400213);

    // Reset mid-drain discards buffered words
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    // Traffic after reset still works
    send(3'd0, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 20'd0, 1'b0, 32'h002081B3);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
Streaming RV32 instruction encoder: the inverse of the control decode path. It takes decoded field bundles (class, funct3, funct7, registers, immediate) and emits legal 32-bit instruction words through a 2-entry output buffer. It is used by the instruction-stream generator and self-test bench to feed the fetch/decode path. Illegal field combinations are replaced by a canonical NOP, flagged, and counted.

Parameters:
DEPTH, 2, output buffer entries; power of two, at least 2.
CNT_W, 16, width of the saturating illegal-request counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request field bundle valid
in_ready  out  1  encoder can accept a bundle
in_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=LUI, 5..7 reserved
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R class only)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  20  immediate; [11:0] for I/LOAD/STORE, [19:0] for LUI
out_valid  out  1  head word valid
out_ready  in  1  consumer accepts the head word
out_instr  out  32  encoded instruction
out_illegal  out  1  head word is a substituted NOP
illegal_cnt  out  CNT_W  saturating count of illegal requests accepted

Behaviour:
- Reset (synchronous, rst high at clk edge): buffer empty, out_valid=0, out_instr=0, out_illegal=0, illegal_cnt=0, in_ready=1 from the cycle after reset. Reset mid-transfer discards all buffered words.
- Accept: in_valid && in_ready. Encoding is combinational on the inputs. The word is written into the buffer at the same edge. Latency is 1 cycle, so the word is visible at the head on the next cycle if the buffer was empty.
- Pop: out_valid && out_ready advances the head.
- in_ready = !full. It is registered-free: it is derived from the buffer occupancy count only and never depends on out_ready.
- Push and pop on the same edge are allowed in any state, and occupancy is unchanged. When full, no push occurs because in_ready=0.
- Pointers wrap modulo DEPTH. The count is 0..DEPTH.
- out_instr and out_illegal hold stable while out_valid && !out_ready.
- Encodings:
  - R: funct7|rs2|rs1|f3|rd|0110011
  - I-ALU: imm[11:0]|rs1|f3|rd|0010011
  - LOAD: imm[11:0]|rs1|f3|rd|0000011
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - LUI: imm[19:0]|rd|0110111
- Legality rules:
  - R: funct7=0000000 is legal for any f3. funct7=0100000 is legal only with f3 000 or 101.
  - I-ALU: f3=001 requires imm[11:5]=0. f3=101 requires imm[11:5] to be 0000000 or 0100000.
  - LOAD: f3 must be one of 000, 001, 010, 100, 101.
  - STORE: f3 must be one of 000, 001, 010.
  - Classes 5..7 are always illegal.
- Illegal request: the word 0x00000013 is stored with out_illegal=1, and illegal_cnt increments (saturating at all ones) on the accept edge.

Optional Feature:
RV32M_ENCODE_EN:
- Defined: R class with funct7=0000001 is legal for all f3 (MUL..REMU).
- Undefined: funct7=0000001 is illegal and the request becomes a NOP with out_illegal=1.
All other behaviour is identical in both builds.

Decomposition:
- Package rv32_isa_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_LUI
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV
  - NOP_WORD = 32'h00000013
  - instr_class_e enum
  - a packed struct for the request bundle
- One sub-module, rv32_enc_fifo: a DEPTH-entry synchronous FIFO carrying {illegal, instr}, with count-based full/empty.
- The combinational encode and legality logic stays in the top level.

Test Plan:
- R ADD: rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_instr=0x002081B3, out_illegal=0, one cycle after accept.
- R SUB then I ADDI back-to-back:
  - SUB: rd=5, rs1=6, rs2=7, f7=0x20 -> 0x407302B3.
  - ADDI: rd=1, rs1=0, imm=5 -> 0x00500093.
  - Both are delivered in order with out_ready=1.
- STORE SW: rs2=5, rs1=2, f3=010, imm=8 -> 0x00512423.
- Illegal SLLI: class=1, f3=001, imm=0x400 -> 0x00000013, out_illegal=1, illegal_cnt=1. Class=6 -> NOP and illegal_cnt=2.
- Backpressure:
  - Hold out_ready=0 and push 3 requests: in_ready drops after 2; the head word is stable.
  - Raise out_ready: words drain in order and in_ready returns the cycle after the first pop.
  - Assert rst mid-drain: out_valid=0 and illegal_cnt=0 on the next cycle.
- MUL: rd=1, rs1=2, rs2=3, f7=0000001:
  - RV32M_ENCODE_EN defined -> 0x023100B3, out_illegal=0.
  - Undefined -> 0x00000013, out_illegal=1.
